// File: rtl/adc_pipe_code_gen.sv
// -----------------------------------------------------------------------------
// adc_pipe_code_gen
//
// Digital stimulus source for the 1.5-bit pipelined ADC encoder. A 3-bit target
// code is decomposed into stage-1 / stage-2 one-hot comparator decisions and a
// final-stage bit, and these are emitted with the stage-to-stage skew of a real
// pipelined converter. A latency-aligned copy of the target code is produced for
// checking the encoder output.
//
// Parameters:
//   STAGE_DLY   cycles between successive stage decisions of a sample (1..3)
//   ENC_LATENCY encoder latency d3 -> d_o, used to align exp_code_o (0..7)
//   REPEAT      slots each code is issued for in sweep mode (1..255)
//
// Ports:
//   clock_i       system clock, rising edge
//   reset_i       asynchronous active-low reset
//   en_i          launch enable (low: no new samples, pipeline drains)
//   mode_i        0 = direct (code_i handshake), 1 = internal sweep
//   code_i        target code in direct mode
//   code_valid_i  code_i valid
//   code_ready_o  code_i accepted this cycle (combinational)
//   d1_o          stage-1 one-hot decision (000 = empty slot)
//   d2_o          stage-2 one-hot decision
//   d3_o          final-stage bit
//   exp_code_o    expected encoder output for the aligned sample
//   exp_valid_o   exp_code_o meaningful this cycle
//   alt_i         (only with ADC_PIPE_CODE_GEN_ALT_DECOMP_EN) use the
//                 alternate redundant decomposition for this launch
//   sweep_done_o  one-cycle pulse with the last repetition of code 7 on d1_o
//
// Optional feature macro: ADC_PIPE_CODE_GEN_ALT_DECOMP_EN
// -----------------------------------------------------------------------------
module adc_pipe_code_gen #(
   parameter int unsigned STAGE_DLY   = 1,
   parameter int unsigned ENC_LATENCY = 1,
   parameter int unsigned REPEAT      = 1
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       en_i,
   input  logic       mode_i,
   input  logic [2:0] code_i,
   input  logic       code_valid_i,
   output logic       code_ready_o,
   output logic [2:0] d1_o,
   output logic [2:0] d2_o,
   output logic       d3_o,
   output logic [2:0] exp_code_o,
   output logic       exp_valid_o,
`ifdef ADC_PIPE_CODE_GEN_ALT_DECOMP_EN
   input  logic       alt_i,
`else
`endif
   output logic       sweep_done_o
);

   localparam logic [7:0] REP_LAST = 8'(REPEAT - 1);

   // Slot records shrink along the pipe: each stage only carries what is
   // still needed downstream. Empty slots are all-zero records.
   typedef struct packed {
      logic       valid;
      logic [2:0] code;
      logic [2:0] d1;
      logic [2:0] d2;
      logic       d3;
   } s1_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
      logic [2:0] d2;
      logic       d3;
   } s2_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
      logic       d3;
   } s3_t;

   typedef struct packed {
      logic       valid;
      logic [2:0] code;
   } ex_t;

   // Decompose code c into {d1, d2, d3}; alt selects the redundant variant
   // (codes 0 and 7 have no alternative and map identically).
   function automatic logic [6:0] decomp(input logic [2:0] c, input logic alt);
      logic [6:0] r;
      case ({alt, c})
         4'b0_000: r = {3'b001, 3'b001, 1'b0};
         4'b0_001: r = {3'b001, 3'b010, 1'b0};
         4'b0_010: r = {3'b010, 3'b001, 1'b0};
         4'b0_011: r = {3'b010, 3'b010, 1'b0};
         4'b0_100: r = {3'b100, 3'b001, 1'b0};
         4'b0_101: r = {3'b100, 3'b010, 1'b0};
         4'b0_110: r = {3'b100, 3'b010, 1'b1};
         4'b0_111: r = {3'b100, 3'b100, 1'b1};
         4'b1_000: r = {3'b001, 3'b001, 1'b0};
         4'b1_001: r = {3'b001, 3'b001, 1'b1};
         4'b1_010: r = {3'b001, 3'b010, 1'b1};
         4'b1_011: r = {3'b001, 3'b100, 1'b1};
         4'b1_100: r = {3'b010, 3'b010, 1'b1};
         4'b1_101: r = {3'b010, 3'b100, 1'b1};
         4'b1_110: r = {3'b100, 3'b100, 1'b0};
         4'b1_111: r = {3'b100, 3'b100, 1'b1};
         default:  r = 7'b000_000_0;
      endcase
      return r;
   endfunction

   logic       code_ready_s;
   logic       launch_s;
   logic [2:0] launch_code_s;
   logic       alt_s;
   logic [6:0] dec_s;
   logic [2:0] sw_code_d, sw_code_q;
   logic [7:0] sw_rep_d, sw_rep_q;
   logic       done_d, done_q;
   s1_t        s1_d, s1_q;
   s2_t [STAGE_DLY-1:0] s2_q;
   s3_t [STAGE_DLY-1:0] s3_q;
   s2_t        s2_in_s;
   s3_t        s3_in_s;
   ex_t        ex_in_s;
   ex_t        ex_out_s;

`ifdef ADC_PIPE_CODE_GEN_ALT_DECOMP_EN
   assign alt_s = alt_i;
`else
   assign alt_s = 1'b0;
`endif

   // Ready is forced low while reset is asserted even though it is combinational.
   assign code_ready_s = en_i & ~mode_i & reset_i;

   // Launch selection, sweep counter advance and stage-1 record build.
   always_comb begin
      launch_s      = 1'b0;
      launch_code_s = 3'd0;
      sw_code_d     = sw_code_q;
      sw_rep_d      = sw_rep_q;
      done_d        = 1'b0;
      s1_d          = '0;
      if (mode_i) begin
         if (en_i) begin
            launch_s      = 1'b1;
            launch_code_s = sw_code_q;
            done_d        = (sw_code_q == 3'd7) && (sw_rep_q == REP_LAST);
            if (sw_rep_q == REP_LAST) begin
               sw_rep_d  = 8'd0;
               sw_code_d = sw_code_q + 3'd1;   // 7 wraps to 0 naturally
            end else begin
               sw_rep_d  = sw_rep_q + 8'd1;
            end
         end else begin
            launch_s = 1'b0;                  // counters hold
         end
      end else begin
         launch_s      = code_valid_i & code_ready_s;
         launch_code_s = code_i;
      end
      dec_s = decomp(launch_code_s, alt_s);
      if (launch_s) begin
         s1_d.valid = 1'b1;
         s1_d.code  = launch_code_s;
         s1_d.d1    = dec_s[6:4];
         s1_d.d2    = dec_s[3:1];
         s1_d.d3    = dec_s[0];
      end else begin
         s1_d = '0;
      end
   end

   assign s2_in_s = {s1_q.valid, s1_q.code, s1_q.d2, s1_q.d3};
   assign s3_in_s = {s2_q[STAGE_DLY-1].valid, s2_q[STAGE_DLY-1].code, s2_q[STAGE_DLY-1].d3};
   assign ex_in_s = {s3_q[STAGE_DLY-1].valid, s3_q[STAGE_DLY-1].code};

   // Stage-1 register, stage-2/3 delay lines and sweep state.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         sw_code_q <= 3'd0;
         sw_rep_q  <= 8'd0;
         done_q    <= 1'b0;
      end else begin
         s1_q    <= s1_d;
         s2_q[0] <= s2_in_s;
         s3_q[0] <= s3_in_s;
         for (int i = STAGE_DLY - 1; i > 0; i--) begin
            s2_q[i] <= s2_q[i-1];
            s3_q[i] <= s3_q[i-1];
         end
         sw_code_q <= sw_code_d;
         sw_rep_q  <= sw_rep_d;
         done_q    <= done_d;
      end
   end

   // Expected-code line; with zero encoder latency it aligns with d3_o.
   if (ENC_LATENCY == 0) begin : g_lat0
      assign ex_out_s = ex_in_s;
   end else begin : g_lat
      ex_t [ENC_LATENCY-1:0] ex_q;

      // Expected-code shift register.
      always_ff @(posedge clock_i or negedge reset_i) begin
         if (!reset_i) begin
            ex_q <= '0;
         end else begin
            ex_q[0] <= ex_in_s;
            for (int i = ENC_LATENCY - 1; i > 0; i--) begin
               ex_q[i] <= ex_q[i-1];
            end
         end
      end

      assign ex_out_s = ex_q[ENC_LATENCY-1];
   end

   assign code_ready_o = code_ready_s;
   assign d1_o         = s1_q.d1;
   assign d2_o         = s2_q[STAGE_DLY-1].d2;
   assign d3_o         = s3_q[STAGE_DLY-1].d3;
   assign exp_code_o   = ex_out_s.code;
   assign exp_valid_o  = ex_out_s.valid;
   assign sweep_done_o = done_q;

endmodule

// File: doc/adc_pipe_code_gen.md
Name: adc_pipe_code_gen

Overview:
- Digital stimulus source for the 1.5-bit pipelined ADC encoder. It is the transmit-side counterpart of that encoder.
- Takes a 3-bit target output code and decomposes it into per-stage comparator decisions: stage 1 and stage 2 one-hot codes, plus the final-stage bit.
- Emits these with the same stage-to-stage pipeline skew a real converter produces, so the encoder can be exercised digitally (loopback/BIST) without an analog front end.
- Also produces a latency-aligned expected code for checking the encoder output.

Parameters:
- STAGE_DLY, 1, clock cycles between successive stage decisions of one sample (d1 → d2 → d3); legal 1..3.
- ENC_LATENCY, 1, encoder latency in cycles from its d3 input to its d_o output; used to align exp_code_o; legal 0..7.
- REPEAT, 1, number of consecutive slots each code is issued in sweep mode; legal 1..255.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- en_i  in  1  launch enable; low → no new samples, pipeline drains.
- mode_i  in  1  0 = direct (code_i handshake), 1 = internal sweep.
- code_i  in  3  target code, direct mode.
- code_valid_i  in  1  code_i valid.
- code_ready_o  out  1  generator accepts code_i this cycle.
- d1_o  out  3  stage-1 one-hot decision (100/010/001, 000 = empty slot).
- d2_o  out  3  stage-2 one-hot decision.
- d3_o  out  1  final-stage bit.
- exp_code_o  out  3  expected encoder output for the aligned sample.
- exp_valid_o  out  1  exp_code_o is meaningful this cycle.
- sweep_done_o  out  1  one-cycle pulse, see Behaviour.

Behaviour:
- Code decomposition:
  - Stage value b maps to code as follows: 0 = 001, 1 = 010, 2 = 100.
  - Encoder relation: C = 2*b1 + b2 + d3.
  - Canonical table, as C: (b1, b2, d3):
    - 0:(0,0,0), 1:(0,1,0), 2:(1,0,0), 3:(1,1,0)
    - 4:(2,0,0), 5:(2,1,0), 6:(2,1,1), 7:(2,2,1)
- Launch slot: one per cycle, taken at rising edge k when:
  - direct mode: code_valid_i & code_ready_o;
  - sweep mode: en_i.
- code_ready_o = en_i & ~mode_i & reset_i (combinational). There is no backpressure beyond that.
- Timing for a sample launched at edge k:
  - d1_o is updated at edge k.
  - d2_o is updated at edge k+STAGE_DLY.
  - d3_o is updated at edge k+2*STAGE_DLY.
  - exp_code_o/exp_valid_o are updated at edge k+2*STAGE_DLY+ENC_LATENCY.
- Empty slots (no launch) propagate through every delay line as d=000, d3=0, exp_valid_o=0. Samples never merge or reorder.
- Delay lines are shift registers of slot records {valid, b-code}. There are 3 delay lines: stage 2, stage 3, and the expected-code line.
- Sweep mode:
  - Code counter starts at 0 and advances after REPEAT launched slots; 7 wraps to 0.
  - A rep counter runs 0..REPEAT-1.
  - sweep_done_o pulses high for one cycle at the same edge d1_o shows the last repetition of code 7.
- Mode change or en_i low mid-operation:
  - In-flight slots always drain unchanged.
  - Sweep code and rep counters hold their values while not launching or while in direct mode; they are not cleared.
- Reset (reset_i low, async):
  - d1_o=000, d2_o=000, d3_o=0, exp_code_o=0, exp_valid_o=0, sweep_done_o=0.
  - All delay lines are emptied; sweep counters = 0.
  - code_ready_o=0 while reset is asserted.
  - Reset mid-operation discards all in-flight samples; the first launch after release appears at d1_o on that launch edge.

Optional Feature:
- Macro ADC_PIPE_CODE_GEN_ALT_DECOMP_EN.
- Defined:
  - Adds input port alt_i (1 bit, sampled with the launch).
  - When alt_i=1, the sample uses the alternate redundant decomposition:
    - 1:(0,0,1), 2:(0,1,1), 3:(0,2,1), 4:(1,1,1), 5:(1,2,1), 6:(2,2,0).
    - 0 and 7 are unchanged.
  - exp_code_o is still the target C, so the bench checks the encoder's redundancy correction.
- Undefined: no alt_i port; canonical table only.

Test Plan:
- Reset release, direct mode, STAGE_DLY=1, ENC_LATENCY=1, code 5 launched at edge k → d1_o=100 after k, d2_o=010 after k+1, d3_o=0 after k+2, exp_code_o=5 with exp_valid_o=1 after k+3 only.
- Back-to-back direct codes 0,7,3 on consecutive edges → d1 sequence 001,100,010; d2 sequence 001,100,010; d3 sequence 0,1,0; exp sequence 0,7,3 on consecutive cycles.
- Sweep mode, REPEAT=2, en_i=1 for 20 cycles → d1 codes follow 0,0,1,1,…,7,7,0; sweep_done_o is high exactly once (with the second issue of 7), aligned with d1_o=100.
- en_i dropped for 2 cycles mid-sweep → 2 empty slots (000/000/0, exp_valid_o=0) appear at each stage; the sweep resumes at the held code with no skip.
- reset_i asserted while 3 samples are in flight → all outputs 0 immediately (async); after release no stale exp_valid_o appears.
- With ADC_PIPE_CODE_GEN_ALT_DECOMP_EN defined, code 4 with alt_i=1 → d1=010, d2=010, d3=1, exp_code_o=4.
